// File: rtl/ifetch_queue.sv
// Instruction fetch unit with a 2-entry {pc, instr} queue feeding decode.
// Define IFETCH_QUEUE_STATS_EN to add fetch/stall event counters.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] iaddr,
    output logic        ireq,
    input  logic [31:0] idata,
    input  logic        iready_n,
    input  logic        stall_ID,
    input  logic        branch_PC_contral,
    input  logic [31:0] branch_target,
    output logic [31:0] Instraction_pype,
    output logic [31:0] PC_pype,
    output logic        valid_pype
`ifdef IFETCH_QUEUE_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        WAIT0,
        RUN,
        FULL,
        REDIR
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    entry_t      e0_q, e0_d;
    entry_t      e1_q, e1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        ireq_q;
    logic        vld_q;
    logic [31:0] ins_q;
    logic [31:0] pco_q;
    logic        push;
    logic        pop;
    entry_t      new_e;

    assign iaddr            = pc_q;
    assign ireq             = ireq_q;
    assign valid_pype       = vld_q;
    assign Instraction_pype = ins_q;
    assign PC_pype          = pco_q;

    assign new_e = '{pc: pc_q, instr: idata};
    assign pop   = (cnt_q != 2'd0) && !stall_ID && !branch_PC_contral;
    assign push  = ireq_q && !iready_n && !branch_PC_contral
                   && ((cnt_q != 2'd2) || pop);

    // e0 is always the head; a pop shifts e1 down.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (branch_PC_contral) begin
            cnt_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = new_e;
                    else e1_d = new_e;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_d = new_e;
                    end else begin
                        e0_d = e1_q;
                        e1_d = new_e;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (branch_PC_contral) begin
            pc_d    = branch_target & 32'hFFFF_FFFC;
            state_d = REDIR;
        end else begin
            if (push) pc_d = pc_q + 32'd4;
            unique case (state_q)
                WAIT0: state_d = RUN;
                RUN:   if (cnt_d == 2'd2) state_d = FULL;
                FULL:  if (pop) state_d = RUN;
                REDIR: state_d = RUN;
                default: state_d = WAIT0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT0;
            pc_q    <= RESET_PC & 32'hFFFF_FFFC;
            e0_q    <= '0;
            e1_q    <= '0;
            cnt_q   <= 2'd0;
            ireq_q  <= 1'b0;
            vld_q   <= 1'b0;
            ins_q   <= NOP_INSTR;
            pco_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            cnt_q   <= cnt_d;
            ireq_q  <= (state_d == RUN);
            vld_q   <= (cnt_d != 2'd0);
            ins_q   <= (cnt_d != 2'd0) ? e0_d.instr : NOP_INSTR;
            pco_q   <= (cnt_d != 2'd0) ? e0_d.pc : 32'd0;
        end
    end

`ifdef IFETCH_QUEUE_STATS_EN
    logic [31:0] fcnt_q, scnt_q;

    assign fetch_count = fcnt_q;
    assign stall_count = scnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q <= 32'd0;
            scnt_q <= 32'd0;
        end else begin
            if (push) fcnt_q <= fcnt_q + 32'd1;
            if (ireq_q && iready_n) scnt_q <= scnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue; consumed instructions are checked
// by a negedge monitor. Covers IFETCH_QUEUE_STATS_EN when defined.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iaddr;
    logic        ireq;
    logic [31:0] idata;
    logic        iready_n;
    logic        stall_ID;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
`ifdef IFETCH_QUEUE_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    // Memory returns a word derived from its address.
    assign idata = iaddr ^ 32'hDEAD_0000;

    ifetch_queue dut (
        .clk              (clk),
        .rst              (rst),
        .iaddr            (iaddr),
        .ireq             (ireq),
        .idata            (idata),
        .iready_n         (iready_n),
        .stall_ID         (stall_ID),
        .branch_PC_contral(br),
        .branch_target    (tgt),
        .Instraction_pype (instr_o),
        .PC_pype          (pc_o),
        .valid_pype       (valid_o)
`ifdef IFETCH_QUEUE_STATS_EN
        ,
        .fetch_count      (fetch_count),
        .stall_count      (stall_count)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic [31:0] ins);
        sb.push_back({pc, ins});
    endtask

    // A head entry is consumed in any cycle decode is not stalled or redirecting.
    always @(negedge clk) begin
        if (rst === 1'b0 && valid_o === 1'b1 && stall_ID === 1'b0
            && br === 1'b0) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected got_pc=%h exp=none", pc_o);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("sb_pc", pc_o, e[63:32]);
                chk("sb_instr", instr_o, e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; iready_n = 1'b0; stall_ID = 1'b0; br = 1'b0; tgt = '0;
        tick(); tick();
        chk("rst_ireq", {31'd0, ireq}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'h0000_0013);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
`ifdef IFETCH_QUEUE_STATS_EN
        chk("rst_fcnt", fetch_count, 32'd0);
        chk("rst_scnt", stall_count, 32'd0);
`endif
        // Streaming fetch from reset
        rst = 1'b0;
        expect_out(32'h0, 32'hDEAD_0000);
        expect_out(32'h4, 32'hDEAD_0004);
        expect_out(32'h8, 32'hDEAD_0008);
        tick();
        chk("run0_iaddr", iaddr, 32'h0);
        chk("run0_ireq", {31'd0, ireq}, 32'd1);
        chk("run0_valid", {31'd0, valid_o}, 32'd0);
        tick();
        chk("run1_iaddr", iaddr, 32'h4);
        chk("run1_pc", pc_o, 32'h0);
        chk("run1_valid", {31'd0, valid_o}, 32'd1);
        tick();
        chk("run2_iaddr", iaddr, 32'h8);
        chk("run2_pc", pc_o, 32'h4);
        tick();
        chk("run3_iaddr", iaddr, 32'hC);
        chk("run3_pc", pc_o, 32'h8);
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_valid", {31'd0, valid_o}, 32'd0);
        chk("mrst_ireq", {31'd0, ireq}, 32'd0);
        chk("mrst_iaddr", iaddr, 32'd0);

        // Decode stall fills the queue
        rst = 1'b0; stall_ID = 1'b1;
        tick();
        chk("st0_iaddr", iaddr, 32'h0);
        tick();
        chk("st1_iaddr", iaddr, 32'h4);
        chk("st1_pc", pc_o, 32'h0);
        tick();
        chk("full_ireq", {31'd0, ireq}, 32'd0);
        chk("full_iaddr", iaddr, 32'h8);
        tick();
        chk("full2_ireq", {31'd0, ireq}, 32'd0);
        chk("full2_iaddr", iaddr, 32'h8);
        chk("full2_pc", pc_o, 32'h0);
        expect_out(32'h0, 32'hDEAD_0000);
        expect_out(32'h4, 32'hDEAD_0004);
        stall_ID = 1'b0;
        tick();
        chk("rel_pc", pc_o, 32'h4);
        chk("rel_ireq", {31'd0, ireq}, 32'd1);
        chk("rel_iaddr", iaddr, 32'h8);
        tick();
        chk("rel2_pc", pc_o, 32'h8);
        chk("rel2_iaddr", iaddr, 32'hC);
        stall_ID = 1'b1;
        tick();
        chk("full3_ireq", {31'd0, ireq}, 32'd0);
        chk("full3_iaddr", iaddr, 32'h10);

        // Redirect while full and stalled
        br = 1'b1; tgt = 32'h0000_0103;
        tick();
        chk("redir_valid", {31'd0, valid_o}, 32'd0);
        chk("redir_ireq", {31'd0, ireq}, 32'd0);
        br = 1'b0; stall_ID = 1'b0;
        tick();
        chk("tgt_iaddr", iaddr, 32'h100);
        chk("tgt_ireq", {31'd0, ireq}, 32'd1);
        expect_out(32'h100, 32'hDEAD_0100);
        tick();
        chk("tgt_pc", pc_o, 32'h100);
        tick();
        chk("tgt2_iaddr", iaddr, 32'h108);
        br = 1'b1; tgt = 32'h0000_0044;
        tick();
        chk("rd1_iaddr", iaddr, 32'h44);
        chk("rd1_ireq", {31'd0, ireq}, 32'd0);
        tgt = 32'h0000_0022;
        tick();
        chk("rd2_iaddr", iaddr, 32'h20);
        chk("rd2_ireq", {31'd0, ireq}, 32'd0);
        chk("rd2_valid", {31'd0, valid_o}, 32'd0);

        // Memory not ready for three cycles
        br = 1'b0; iready_n = 1'b1;
        tick();
        chk("nr0_ireq", {31'd0, ireq}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nr_iaddr", iaddr, 32'h20);
            chk("nr_valid", {31'd0, valid_o}, 32'd0);
        end
`ifdef IFETCH_QUEUE_STATS_EN
        chk("stat_scnt", stall_count, 32'd3);
        chk("stat_fcnt", fetch_count, 32'd6);
`endif
        iready_n = 1'b0;
        expect_out(32'h20, 32'hDEAD_0020);
        tick();
        chk("nr_pc", pc_o, 32'h20);
        chk("nr_next", iaddr, 32'h24);
        tick();
        br = 1'b1; tgt = 32'hFFFF_FFFB;
        tick();
        chk("wrp_iaddr", iaddr, 32'hFFFF_FFF8);
        br = 1'b0;
        expect_out(32'hFFFF_FFF8, 32'h2152_FFF8);
        expect_out(32'hFFFF_FFFC, 32'h2152_FFFC);
        expect_out(32'h0, 32'hDEAD_0000);
        tick();
        chk("wrp0_iaddr", iaddr, 32'hFFFF_FFF8);
        tick();
        chk("wrp1_iaddr", iaddr, 32'hFFFF_FFFC);
        tick();
        chk("wrp2_iaddr", iaddr, 32'h0);
        tick();
        chk("wrp3_iaddr", iaddr, 32'h4);
        tick();

        // Reset overrides a simultaneous redirect
        rst = 1'b1; br = 1'b1; tgt = 32'h500; stall_ID = 1'b1;
        tick();
        chk("rb_valid", {31'd0, valid_o}, 32'd0);
        chk("rb_instr", instr_o, 32'h0000_0013);
        chk("rb_pc", pc_o, 32'd0);
        chk("rb_iaddr", iaddr, 32'd0);
        chk("rb_ireq", {31'd0, ireq}, 32'd0);
`ifdef IFETCH_QUEUE_STATS_EN
        chk("rb_fcnt", fetch_count, 32'd0);
`endif
        rst = 1'b0; br = 1'b0;
        tick();
        chk("rb_run_ireq", {31'd0, ireq}, 32'd1);
        chk("rb_run_iaddr", iaddr, 32'd0);
        tick(); tick();
        chk("sb_left", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, instruction word presented when no valid entry exists.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port iaddr, output, 32, instruction memory address; low two bits always 0.
REQ-006 SHALL have port ireq, output, 1, fetch request valid for iaddr.
REQ-007 SHALL have port idata, input, 32, instruction word for iaddr, same cycle.
REQ-008 SHALL have port iready_n, input, 1, low = idata valid this cycle; high = memory not ready.
REQ-009 SHALL have port stall_ID, input, 1, decode holds; head entry not consumed.
REQ-010 SHALL have port branch_PC_contral, input, 1, branch/jump taken; redirect fetch.
REQ-011 SHALL have port branch_target, input, 32, redirect address.
REQ-012 SHALL have port Instraction_pype, output, 32, head instruction to decode.
REQ-013 SHALL have port PC_pype, output, 32, address of head instruction.
REQ-014 SHALL have port valid_pype, output, 1, head entry valid.

Function
REQ-015 SHALL contain a 2-entry FIFO of {pc, instr} with a 2-bit occupancy count 0..2.
REQ-016 SHALL implement states WAIT0, RUN, FULL, REDIR.
REQ-017 SHALL drive ireq=1 only in RUN; ireq=0 in WAIT0, FULL, REDIR.
REQ-018 Push: in RUN with ireq=1 and iready_n=0 and branch_PC_contral=0, SHALL write {fetch_pc, idata} at tail and advance fetch_pc by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-019 iready_n=1 SHALL leave fetch_pc and FIFO unchanged (request held, iaddr stable).
REQ-020 Pop: when count>0 and stall_ID=0 and branch_PC_contral=0, SHALL remove head at clock edge.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; push when count=2 SHALL occur only if pop occurs same cycle.
REQ-022 Outputs SHALL be registered from FIFO head: count>0 -> head fields, valid_pype=1; count=0 -> Instraction_pype=NOP_INSTR, PC_pype=0, valid_pype=0.
REQ-023 Transitions: WAIT0->RUN after one cycle; RUN->FULL when count becomes 2 and no pop; FULL->RUN on pop; any state->REDIR on branch_PC_contral=1; REDIR->RUN after one cycle.
REQ-024 branch_PC_contral=1 SHALL take priority over stall_ID, push and pop: FIFO flushed (count=0), fetch_pc <= {branch_target[31:2],2'b00}, same-cycle idata discarded.
REQ-025 REDIR SHALL insert exactly one bubble cycle (ireq=0, valid_pype=0); first new-target request issued in following RUN cycle.
REQ-026 branch_PC_contral asserted while already in REDIR SHALL reload fetch_pc with the newer target and remain in REDIR one more cycle.
REQ-027 Minimum latency SHALL be 1 cycle: instruction accepted at edge N appears on Instraction_pype after edge N when FIFO was empty.

Reset
REQ-028 On rst=1 at clock edge: state=WAIT0, fetch_pc=RESET_PC, count=0, ireq=0, valid_pype=0, Instraction_pype=NOP_INSTR, PC_pype=0.
REQ-029 Reset mid-operation SHALL discard all FIFO entries and any pending request; rst SHALL override branch_PC_contral.

Configuration
REQ-030 Macro IFETCH_QUEUE_STATS_EN defined: SHALL add outputs fetch_count[31:0] (increments per push) and stall_count[31:0] (increments per cycle with ireq=1 and iready_n=1), both cleared by rst, wrapping at 2^32.
REQ-031 Macro IFETCH_QUEUE_STATS_EN undefined: counters and ports SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset then iready_n=0, stall_ID=0 -> iaddr 0,4,8 on consecutive RUN cycles; PC_pype 0,4,8 one cycle later, valid_pype=1.
REQ-033 stall_ID=1 for 4 cycles, iready_n=0 -> count reaches 2, state FULL, ireq=0, iaddr held at 8; release -> PC_pype 0 then 4, fetch resumes at 8.
REQ-034 branch_PC_contral=1, branch_target=32'h0000_0103 while FULL and stall_ID=1 -> next cycle valid_pype=0, ireq=0; following cycle iaddr=32'h0000_0100.
REQ-035 iready_n=1 for 3 cycles at iaddr 32'h20 -> iaddr stable, no push; with IFETCH_QUEUE_STATS_EN stall_count increments by 3.
REQ-036 RESET_PC=32'hFFFF_FFF8, iready_n=0 -> iaddr FFFF_FFF8, FFFF_FFFC, 0000_0000; rst=1 mid-stream -> next cycle valid_pype=0, Instraction_pype=32'h0000_0013.
